// File: rtl/line_memory_if.sv
// line_memory_if: request/response bundle between the cache controller's
// memory port (master) and the line_memory backing store (slave).
//   enable_i  request valid, held by the master until it sees ack_o
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address of the 256-bit line
//   data_i    write data
//   ack_o     one-cycle completion pulse
//   data_o    read data, valid while ack_o is high
interface line_memory_if #(
  parameter int ADDR_W = 32
);
  logic              enable_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [255:0]      data_i;
  logic              ack_o;
  logic [255:0]      data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/line_memory.sv
// line_memory: slow main-memory model behind the data cache refill/write-back
// port. Accepts one 256-bit line request at a time, answers LATENCY cycles
// after acceptance with a single-cycle ack_o (and read data for reads).
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset (array contents untouched)
//   bus         line_memory_if slave: enable/write/addr/data in, ack/data out
//   rd_count_o  completed reads  (only with LINE_MEMORY_STATS_EN defined)
//   wr_count_o  completed writes (only with LINE_MEMORY_STATS_EN defined)
// Optional feature macro: LINE_MEMORY_STATS_EN adds the two 32-bit
// transaction counters; without it the block is functionally identical.
module line_memory #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10,
  parameter int ADDR_W  = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  line_memory_if.slave bus
`ifdef LINE_MEMORY_STATS_EN
  ,
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ack_nxt;
  logic             accept;
  logic             commit;
  logic             fetch;

  logic             req_write;
  logic [IDX_W-1:0] req_idx;
  logic [255:0]     req_data;

  logic [255:0]     mem [DEPTH];

  // Offset bits and bits above the index are deliberately ignored, so the
  // address aliases modulo DEPTH lines.
  logic [ADDR_W-1:0] unused_addr;
  assign unused_addr = bus.addr_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.ack_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bus.ack_o <= ack_nxt;
    end
  end

  // The counter is loaded with LATENCY-1 at acceptance and the ack is
  // registered on the edge where it reaches zero, which lands the pulse
  // exactly LATENCY edges after acceptance.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack_nxt   = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    fetch     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable_i) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ACK;
          ack_nxt   = 1'b1;
          commit    = req_write;
          fetch     = !req_write;
        end
      end
      ACK: begin
        // enable_i is not looked at here, so a held request cannot be
        // re-accepted before the master has seen the ack.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once at acceptance; later changes on the
  // bus are invisible to the transaction in flight.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_write <= bus.write_i;
      req_idx   <= bus.addr_i[5 +: IDX_W];
      req_data  <= bus.data_i;
    end
  end

  // commit is only ever raised from WAIT, and reset forces IDLE, so an
  // aborted transaction can never reach the array.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem[req_idx] <= req_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.data_o <= '0;
    end else if (fetch) begin
      bus.data_o <= mem[req_idx];
    end
  end

`ifdef LINE_MEMORY_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      if (fetch) begin
        rd_count_o <= rd_count_o + 32'd1;
      end
      if (commit) begin
        wr_count_o <= wr_count_o + 32'd1;
      end
    end
  end
`endif

endmodule
